opcode_fetch: RTL and testbench
===============================

// Module: opcode_fetch
// PURPOSE
//  Downstream neighbour of the program-counter stage. Reads the 2-byte big-endian CHIP-8 opcode at the PC
//  from byte-wide synchronous RAM and holds it for decode under a valid/ready handshake.
//  Splits it into the standard fields and drives stall back to the PC stage until the opcode is consumed.
// PARAMETERS
//  ADDR_W   12  RAM byte-address width (4 KiB)
//  MEM_LAT  1   RAM read latency in cycles, legal 1..3
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst        in   1       asynchronous, active-low reset (0 = reset)
//  pc         in   16      current program counter from PC stage
//  flush      in   1       branch/skip taken: abort current opcode
//  stall      out  1       to PC stage: hold PC this cycle
//  mem_addr   out  ADDR_W  RAM byte address
//  mem_rd     out  1       RAM read strobe, 1 cycle per byte
//  mem_rdata  in   8       RAM read data, valid MEM_LAT cycles after mem_rd
//  op_valid   out  1       opcode held and valid
//  op_ready   in   1       decode accepts opcode
//  opcode     out  16      {hi_byte, lo_byte}
//  op_pc      out  16      PC the opcode was read from
//  op_x/op_y  out  4 each  opcode[11:8] / opcode[7:4]
//  op_n/op_nn/op_nnn out 4/8/12  opcode[3:0] / [7:0] / [11:0]
//  pc_fault   out  1       sticky: odd PC or PC beyond 2^ADDR_W-2
//  op_illegal out  1       opcode not in CHIP-8 set (ILLEGAL_OP_CHECK_EN only)
// BEHAVIOUR
//  Reset (rst=0, async): state=REQ_HI, latency counter 0, opcode/op_pc=0, op_valid=0, mem_rd=0, pc_fault=0.
//  After reset, stall=1 and op_illegal=0.
//  States: REQ_HI -> WAIT_HI -> REQ_LO -> WAIT_LO -> VALID -> REQ_HI; FAULT is terminal.
//  REQ_HI: sample pc into op_pc, mem_addr=pc[ADDR_W-1:0], mem_rd=1.
//    If pc[0]=1 or pc[15:ADDR_W]!=0 or pc[ADDR_W-1:0]=all ones, go to FAULT and set pc_fault.
//  WAIT_HI: count MEM_LAT cycles; on the last, latch mem_rdata into opcode[15:8].
//  REQ_LO: mem_addr=op_pc+1, mem_rd=1. WAIT_LO: as WAIT_HI, latching opcode[7:0].
//  VALID: op_valid=1; opcode and fields are stable until handshake. On op_valid&op_ready, go to REQ_HI next cycle.
//  mem_rd is 0 and mem_addr holds its last value outside REQ_*.
//  Latency: REQ_HI entry to op_valid=1 is 2*MEM_LAT+2 cycles (MEM_LAT=1: 4). Max one opcode per 2*MEM_LAT+3 cycles.
//  stall = !(state==VALID && op_ready), combinational, so the PC advances exactly on the consume cycle.
//  Field outputs are combinational slices of the opcode register.
//  flush: from any state except FAULT, next state is REQ_HI, op_valid=0, counter cleared.
//    Data of an in-flight read is discarded; a late mem_rdata is never latched.
//  flush with the handshake in the same cycle: the opcode counts as consumed, next state is still REQ_HI.
//  FAULT: op_valid=0, stall=1, mem_rd=0. Exit only via rst; flush is ignored.
//  op_ready while op_valid=0 is ignored. No combinational path from op_ready to mem_*.
// CONFIGURATION
//  ILLEGAL_OP_CHECK_EN defined: op_illegal is decoded combinationally from opcode and qualified by op_valid.
//  Illegal means any of:
//   - 5xyN with N!=0
//   - 8xyN with N in {8..D,F}
//   - 9xyN with N!=0
//   - ExNN with NN not in {9E,A1}
//   - FxNN with NN not in {07,0A,15,18,1E,29,33,55,65}
//  0NNN counts as legal. Legality does not affect the handshake.
//  ILLEGAL_OP_CHECK_EN undefined: op_illegal is tied to 0 and no decode logic is built.
// TESTING
//  1. MEM_LAT=1. RAM[0x70]=0x12, RAM[0x71]=0x34, pc=0x0070, op_ready=1.
//     -> op_valid 4 cycles after REQ_HI; opcode=0x1234, op_nnn=0x234, op_pc=0x0070; stall=0 for exactly 1 cycle.
//  2. op_ready=0 for 10 cycles after op_valid.
//     -> opcode, op_pc and the fields are stable; stall=1 throughout; mem_rd=0.
//  3. flush asserted during WAIT_LO with pc changed to 0x0200, RAM[0x200..0x201]=0xA2F0.
//     -> no op_valid for the old PC; next opcode=0xA2F0, op_pc=0x0200.
//  4. pc=0x0071 (odd) at REQ_HI.
//     -> pc_fault=1 next cycle; op_valid stays 0 and stall stays 1 for 20 cycles, flush pulses included.
//     -> rst low clears the fault.
//  5. MEM_LAT=3, opcode 0xD125.
//     -> op_valid 8 cycles after REQ_HI; op_x=1, op_y=2, op_n=5.
//     -> mem_rd pulses exactly twice, addresses pc and pc+1.
//  6. ILLEGAL_OP_CHECK_EN defined: opcodes 0x8008, 0xE09E, 0xF0FF.
//     -> op_illegal = 1, 0, 1 while op_valid; with the macro undefined, always 0.

Source files
------------

// File: rtl/opcode_fetch.sv
// Fetches a 2-byte big-endian CHIP-8 opcode at pc from byte RAM and holds it for decode; optional ILLEGAL_OP_CHECK_EN flags illegal opcodes.
// Latency: 2*MEM_LAT+2 cycles from REQ_HI entry to op_valid; at most one opcode per 2*MEM_LAT+3 cycles.
// Backpressure: opcode held in VALID until op_valid&op_ready; stall to the PC stage stays high until that consume cycle.
module opcode_fetch #(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       pc,
    input  logic              flush,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [15:0]       opcode,
    output logic [15:0]       op_pc,
    output logic [3:0]        op_x,
    output logic [3:0]        op_y,
    output logic [3:0]        op_n,
    output logic [7:0]        op_nn,
    output logic [11:0]       op_nnn,
    output logic              pc_fault,
    output logic              op_illegal
);

    localparam logic [2:0] REQ_HI  = 3'd0;
    localparam logic [2:0] WAIT_HI = 3'd1;
    localparam logic [2:0] REQ_LO  = 3'd2;
    localparam logic [2:0] WAIT_LO = 3'd3;
    localparam logic [2:0] VALID   = 3'd4;
    localparam logic [2:0] FAULT   = 3'd5;

    localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [1:0]        cnt;
    logic              cnt_last;
    logic              pc_bad;
    logic              flush_act;
    logic [ADDR_W-1:0] addr_q;

    assign cnt_last  = (cnt == LAST);
    assign flush_act = flush && (state != FAULT);
    // Last byte of the space is odd, but the explicit all-ones test keeps intent clear.
    assign pc_bad    = pc[0] || (pc[15:ADDR_W] != '0) || (&pc[ADDR_W-1:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            REQ_HI:  state_nxt = pc_bad ? FAULT : WAIT_HI;
            WAIT_HI: if (cnt_last) state_nxt = REQ_LO;
            REQ_LO:  state_nxt = WAIT_LO;
            WAIT_LO: if (cnt_last) state_nxt = VALID;
            VALID:   if (op_ready) state_nxt = REQ_HI;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = REQ_HI;
        endcase
        if (flush_act) begin
            state_nxt = REQ_HI;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= REQ_HI;
            cnt      <= 2'd0;
            opcode   <= 16'h0000;
            op_pc    <= 16'h0000;
            pc_fault <= 1'b0;
            addr_q   <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= mem_addr;
            if (flush_act) begin
                cnt <= 2'd0;
            end else if (state == WAIT_HI || state == WAIT_LO) begin
                cnt <= cnt_last ? 2'd0 : cnt + 2'd1;
            end
            // A flushed read is never latched, so late data of an aborted fetch cannot land.
            if (!flush_act && cnt_last && state == WAIT_HI) begin
                opcode[15:8] <= mem_rdata;
            end
            if (!flush_act && cnt_last && state == WAIT_LO) begin
                opcode[7:0] <= mem_rdata;
            end
            if (state == REQ_HI) begin
                op_pc <= pc;
            end
            if (state == REQ_HI && pc_bad && !flush_act) begin
                pc_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr = addr_q;
        case (state)
            REQ_HI:  mem_addr = pc[ADDR_W-1:0];
            REQ_LO:  mem_addr = {op_pc[ADDR_W-1:1], 1'b1};
            default: mem_addr = addr_q;
        endcase
    end

    assign mem_rd   = rst && (state == REQ_HI || state == REQ_LO);
    assign op_valid = (state == VALID);
    assign stall    = !(op_valid && op_ready);

    assign op_x   = opcode[11:8];
    assign op_y   = opcode[7:4];
    assign op_n   = opcode[3:0];
    assign op_nn  = opcode[7:0];
    assign op_nnn = opcode[11:0];

`ifdef ILLEGAL_OP_CHECK_EN
    logic illegal;

    always_comb begin
        illegal = 1'b0;
        case (opcode[15:12])
            4'h5: illegal = (op_n != 4'h0);
            4'h8: illegal = (op_n >= 4'h8) && (op_n != 4'hE);
            4'h9: illegal = (op_n != 4'h0);
            4'hE: illegal = (op_nn != 8'h9E) && (op_nn != 8'hA1);
            4'hF: begin
                case (op_nn)
                    8'h07, 8'h0A, 8'h15, 8'h18, 8'h1E,
                    8'h29, 8'h33, 8'h55, 8'h65: illegal = 1'b0;
                    default:                    illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b0;
        endcase
    end

    assign op_illegal = op_valid && illegal;
`else
    assign op_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_fetch.sv
// Scoreboard bench for opcode_fetch: one instance at MEM_LAT=1, one at MEM_LAT=3, each with a pipelined RAM model.
module tb_opcode_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_e;

    // MEM_LAT=1 instance
    logic [15:0] pc1;
    logic        flush1, ready1;
    logic        stall1, mem_rd1, op_valid1, pc_fault1, op_illegal1;
    logic [11:0] mem_addr1;
    logic [7:0]  rdata1;
    logic [15:0] opcode1, op_pc1;
    logic [3:0]  op_x1, op_y1, op_n1;
    logic [7:0]  op_nn1;
    logic [11:0] op_nnn1;
    logic [7:0]  mem1 [0:4095];
    logic [7:0]  p1;

    // MEM_LAT=3 instance
    logic [15:0] pc3;
    logic        flush3, ready3;
    logic        stall3, mem_rd3, op_valid3, pc_fault3, op_illegal3;
    logic [11:0] mem_addr3;
    logic [7:0]  rdata3;
    logic [15:0] opcode3, op_pc3;
    logic [3:0]  op_x3, op_y3, op_n3;
    logic [7:0]  op_nn3;
    logic [11:0] op_nnn3;
    logic [7:0]  mem3 [0:4095];
    logic [7:0]  p3 [0:2];

    opcode_fetch #(.ADDR_W(12), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .pc(pc1), .flush(flush1), .stall(stall1),
        .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_rdata(rdata1),
        .op_valid(op_valid1), .op_ready(ready1), .opcode(opcode1), .op_pc(op_pc1),
        .op_x(op_x1), .op_y(op_y1), .op_n(op_n1), .op_nn(op_nn1), .op_nnn(op_nnn1),
        .pc_fault(pc_fault1), .op_illegal(op_illegal1)
    );

    opcode_fetch #(.ADDR_W(12), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .pc(pc3), .flush(flush3), .stall(stall3),
        .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_rdata(rdata3),
        .op_valid(op_valid3), .op_ready(ready3), .opcode(opcode3), .op_pc(op_pc3),
        .op_x(op_x3), .op_y(op_y3), .op_n(op_n3), .op_nn(op_nn3), .op_nnn(op_nnn3),
        .pc_fault(pc_fault3), .op_illegal(op_illegal3)
    );

    // RAM models: data is only defined exactly MEM_LAT cycles after a read strobe.
    always @(posedge clk) begin
        p1    <= mem_rd1 ? mem1[mem_addr1] : 8'hxx;
        p3[0] <= mem_rd3 ? mem3[mem_addr3] : 8'hxx;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata1 = p1;
    assign rdata3 = p3[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid1(output int n);
        n = 0;
        while (!op_valid1 && n < 40) begin
            step();
            n++;
        end
        if (!op_valid1) n = -1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[12'h070] = 8'h12; mem1[12'h071] = 8'h34;
        mem1[12'h072] = 8'h6A; mem1[12'h073] = 8'h55;
        mem1[12'h074] = 8'h11; mem1[12'h075] = 8'h22;
        mem1[12'h200] = 8'hA2; mem1[12'h201] = 8'hF0;
        mem1[12'h100] = 8'h80; mem1[12'h101] = 8'h08;
        mem1[12'h102] = 8'hE0; mem1[12'h103] = 8'h9E;
        mem1[12'h104] = 8'hF0; mem1[12'h105] = 8'hFF;
        mem3[12'h300] = 8'hD1; mem3[12'h301] = 8'h25;
        pc1 = 16'h0070; flush1 = 1'b0; ready1 = 1'b1;
        pc3 = 16'h0300; flush3 = 1'b0; ready3 = 1'b0;
        rst = 1'b0;
        step();
        step();
        total++;
        if ({op_valid1, stall1, mem_rd1, pc_fault1, op_illegal1} !== 5'b01000)
            begin bad++; $display("FAIL reset_ctrl got v/s/rd/f/ill=%b want 01000",
                {op_valid1, stall1, mem_rd1, pc_fault1, op_illegal1}); end
        total++;
        if (opcode1 !== 16'h0000 || op_pc1 !== 16'h0000)
            begin bad++; $display("FAIL reset_regs got opcode=%h op_pc=%h want 0000/0000", opcode1, op_pc1); end
    endtask

    task automatic test_basic();
        int n;
        int zeros;
        exp_q.push_back({16'h1234, 16'h0070});
        rst = 1'b1;
        #1;
        total++;
        if (mem_rd1 !== 1'b1 || mem_addr1 !== 12'h070)
            begin bad++; $display("FAIL basic_req_hi got rd=%b addr=%h want 1/070", mem_rd1, mem_addr1); end
        step();
        wait_valid1(n);
        n++;
        total++;
        if (n !== 4) begin bad++; $display("FAIL basic_latency got %0d want 4", n); end
        exp_e = exp_q.pop_front();
        total++;
        if (opcode1 !== exp_e[31:16] || op_pc1 !== exp_e[15:0] || op_nnn1 !== 12'h234)
            begin bad++; $display("FAIL basic_data got op=%h pc=%h nnn=%h want %h/%h/234",
                opcode1, op_pc1, op_nnn1, exp_e[31:16], exp_e[15:0]); end
        zeros = (stall1 === 1'b0) ? 1 : 0;
        step();
        ready1 = 1'b0;
        pc1 = 16'h0072;
        exp_q.push_back({16'h6A55, 16'h0072});
        for (int i = 0; i < 4; i++) begin
            if (stall1 === 1'b0) zeros++;
            step();
        end
        total++;
        if (zeros !== 1) begin bad++; $display("FAIL basic_stall_pulse got %0d low cycles want 1", zeros); end
    endtask

    task automatic test_hold();
        int n;
        wait_valid1(n);
        total++;
        if (n < 0) begin bad++; $display("FAIL hold_timeout got no op_valid want op_valid"); end
        exp_e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (op_valid1 !== 1'b1 || opcode1 !== exp_e[31:16] || op_pc1 !== exp_e[15:0] ||
                op_x1 !== 4'hA || op_y1 !== 4'h5 || op_n1 !== 4'h5 || op_nn1 !== 8'h55 ||
                op_nnn1 !== 12'hA55 || stall1 !== 1'b1 || mem_rd1 !== 1'b0)
                begin bad++; $display("FAIL hold_cycle%0d got v=%b op=%h pc=%h st=%b rd=%b want 1/%h/%h/1/0",
                    i, op_valid1, opcode1, op_pc1, stall1, mem_rd1, exp_e[31:16], exp_e[15:0]); end
            step();
        end
        ready1 = 1'b1;
        #1;
        total++;
        if (stall1 !== 1'b0) begin bad++; $display("FAIL hold_consume_stall got %b want 0", stall1); end
        step();
        ready1 = 1'b0;
        pc1 = 16'h0074;
    endtask

    task automatic test_flush();
        int n;
        int found;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd1 === 1'b1 && mem_addr1 === 12'h075) begin found = 1; break; end
            step();
        end
        total++;
        if (found !== 1) begin bad++; $display("FAIL flush_req_lo got none want read at 075"); end
        step();
        flush1 = 1'b1;
        pc1 = 16'h0200;
        exp_q.push_back({16'hA2F0, 16'h0200});
        step();
        flush1 = 1'b0;
        ready1 = 1'b1;
        wait_valid1(n);
        total++;
        if (n !== 4) begin bad++; $display("FAIL flush_latency got %0d want 4", n); end
        exp_e = exp_q.pop_front();
        total++;
        if (opcode1 !== exp_e[31:16] || op_pc1 !== exp_e[15:0])
            begin bad++; $display("FAIL flush_data got op=%h pc=%h want %h/%h",
                opcode1, op_pc1, exp_e[31:16], exp_e[15:0]); end
        step();
        pc1 = 16'h0071;
        ready1 = 1'b0;
    endtask

    task automatic test_fault();
        step();
        total++;
        if (pc_fault1 !== 1'b1) begin bad++; $display("FAIL fault_set got %b want 1", pc_fault1); end
        ready1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            flush1 = (i % 3 == 0);
            #1;
            total++;
            if (op_valid1 !== 1'b0 || stall1 !== 1'b1 || mem_rd1 !== 1'b0 || pc_fault1 !== 1'b1)
                begin bad++; $display("FAIL fault_hold%0d got v/s/rd/f=%b%b%b%b want 0101",
                    i, op_valid1, stall1, mem_rd1, pc_fault1); end
            step();
        end
        flush1 = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (pc_fault1 !== 1'b0) begin bad++; $display("FAIL fault_clear got %b want 0", pc_fault1); end
        pc1 = 16'h0070;
    endtask

    task automatic test_lat3();
        int n;
        int rds;
        logic [11:0] a0, a1;
        n = 0; rds = 0; a0 = '0; a1 = '0;
        ready3 = 1'b1;
        exp_q.push_back({16'hD125, 16'h0300});
        step();
        rst = 1'b1;
        #1;
        while (!op_valid3 && n < 40) begin
            if (mem_rd3 === 1'b1) begin
                if (rds == 0) a0 = mem_addr3; else a1 = mem_addr3;
                rds++;
            end
            step();
            n++;
        end
        total++;
        if (n !== 8) begin bad++; $display("FAIL lat3_latency got %0d want 8", n); end
        total++;
        if (rds !== 2 || a0 !== 12'h300 || a1 !== 12'h301)
            begin bad++; $display("FAIL lat3_reads got %0d at %h,%h want 2 at 300,301", rds, a0, a1); end
        exp_e = exp_q.pop_front();
        total++;
        if (opcode3 !== exp_e[31:16] || op_pc3 !== exp_e[15:0] ||
            op_x3 !== 4'h1 || op_y3 !== 4'h2 || op_n3 !== 4'h5)
            begin bad++; $display("FAIL lat3_fields got op=%h x=%h y=%h n=%h want %h/1/2/5",
                opcode3, op_x3, op_y3, op_n3, exp_e[31:16]); end
        step();
        ready3 = 1'b0;
    endtask

    task automatic test_illegal();
        int n;
        logic [2:0] ill_exp;
`ifdef ILLEGAL_OP_CHECK_EN
        ill_exp = 3'b101;
`else
        ill_exp = 3'b000;
`endif
        ready1 = 1'b0;
        exp_q.push_back({16'h8008, 16'h0100});
        exp_q.push_back({16'hE09E, 16'h0102});
        exp_q.push_back({16'hF0FF, 16'h0104});
        for (int k = 0; k < 3; k++) begin
            pc1 = 16'h0100 + 16'(2 * k);
            flush1 = 1'b1;
            step();
            flush1 = 1'b0;
            wait_valid1(n);
            exp_e = exp_q.pop_front();
            total++;
            if (n < 0 || opcode1 !== exp_e[31:16] || op_illegal1 !== ill_exp[2-k])
                begin bad++; $display("FAIL illegal_%h got op=%h ill=%b want %h/%b",
                    exp_e[31:16], opcode1, op_illegal1, exp_e[31:16], ill_exp[2-k]); end
            ready1 = 1'b1;
            step();
            ready1 = 1'b0;
            total++;
            if (op_illegal1 !== 1'b0)
                begin bad++; $display("FAIL illegal_qual_%0d got %b want 0", k, op_illegal1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_flush();
        test_fault();
        test_lat3();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
